// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Purpose  : Shared control-path types and constants for the fetch queue
//            and the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

    // Widest program counter any core variant uses; narrower PCs are
    // zero-extended into the entry and truncated on the way out.
    localparam int PC_MAX_W = 64;

    // addi x0, x0, 0 - presented to decode whenever the queue has nothing valid.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // One queued fetch: the PC and the instruction word fetched from it.
    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [31:0]         instr;
    } fq_entry_t;

endpackage : control_pkg
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_if
// Purpose  : Fetch-to-decode handshake bundle around the fetch queue.
//            master = fetch/decode side, slave = the queue itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) ();

    logic                     in_valid;
    logic [31:0]              in_instr;
    logic [XLEN-1:0]          in_pc;
    logic                     in_ready;
    logic                     flush;

    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_instr;
    logic [XLEN-1:0]          out_pc;
    logic [6:0]               out_opcode;
    logic [2:0]               out_funct3;

    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_opcode, out_funct3, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_opcode, out_funct3, count
    );

endinterface : fetch_queue_if
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : First-word fall-through instruction queue between fetch and
//            decode. Flush discards everything on a redirect. DEPTH must be
//            a power of two >= 2 so the pointers wrap naturally; XLEN <= 64.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import control_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  wire logic  clk,
    input  wire logic  reset,
    fetch_queue_if.slave fq
);

    localparam int             c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_DEPTH = (c_AW + 1)'(DEPTH);

    // Storage is deliberately left unreset; occupancy alone defines validity.
    fq_entry_t         r_mem [DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_AW:0]     r_count;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    fq_entry_t         w_head;
    logic [31:0]       w_out_instr;

    // in_ready depends only on stored occupancy, never on out_ready, so a
    // full queue refuses a push even while it is being popped.
    assign w_in_ready  = (r_count < c_DEPTH);
    assign w_out_valid = (r_count != '0) && !fq.flush;
    assign w_push      = fq.in_valid && w_in_ready && !fq.flush;
    // w_out_valid already masks flush, so a pop during flush is ignored.
    assign w_pop       = w_out_valid && fq.out_ready;

    assign w_head      = r_mem[r_rptr];
    assign w_out_instr = w_out_valid ? w_head.instr : NOP_INSTR;

    assign fq.in_ready   = w_in_ready;
    assign fq.out_valid  = w_out_valid;
    assign fq.out_instr  = w_out_instr;
    assign fq.out_pc     = w_out_valid ? XLEN'(w_head.pc) : '0;
    assign fq.out_opcode = w_out_instr[6:0];
    assign fq.out_funct3 = w_out_instr[14:12];
    assign fq.count      = r_count;

    // Write the incoming fetch into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{pc: PC_MAX_W'(fq.in_pc), instr: fq.in_instr};
        end
    end

    // Pointer and occupancy tracking; flush and reset both empty the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (fq.flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Self-checking bench for fetch_queue (DEPTH=4, XLEN=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
    import control_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic clk;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) fq ();

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of entries the queue is expected to hold, head first.
    fq_entry_t sb[$];

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        ready;
        logic        flush;
        logic [2:0]  exp_count;
        logic        exp_in_ready;
        logic        exp_out_valid;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        fq.in_valid  = v;
        fq.in_instr  = ins;
        fq.in_pc     = pc;
        fq.out_ready = rdy;
        fq.flush     = fl;
    endtask

    // Compare outputs against the scoreboard, then predict the next edge.
    task automatic evaluate_and_advance();
        logic       exp_ov;
        logic       exp_ir;
        logic       do_push;
        logic       do_pop;
        logic [31:0] ei;
        exp_ir = (sb.size() < DEPTH);
        exp_ov = (sb.size() != 0) && !fq.flush;
        check("in_ready", 64'(fq.in_ready), 64'(exp_ir));
        check("out_valid", 64'(fq.out_valid), 64'(exp_ov));
        check("count", 64'(fq.count), 64'(sb.size()));
        ei = exp_ov ? sb[0].instr : NOP_INSTR;
        check("out_instr", 64'(fq.out_instr), 64'(ei));
        check("out_pc", fq.out_pc, exp_ov ? sb[0].pc : 64'h0);
        check("out_opcode", 64'(fq.out_opcode), 64'(ei[6:0]));
        check("out_funct3", 64'(fq.out_funct3), 64'(ei[14:12]));
        do_pop  = exp_ov && fq.out_ready;
        do_push = fq.in_valid && exp_ir && !fq.flush;
        if (fq.flush) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back('{pc: fq.in_pc, instr: fq.in_instr});
        end
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic rdy, input logic fl);
        drive(v, ins, pc, rdy, fl);
        #1;
        evaluate_and_advance();
    endtask

    initial begin
        // valid instr         pc        rdy flush cnt ir ov
        vecs[0]  = '{1'b1, 32'h0050_0093, 64'h1000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h0020_8133, 64'h1004, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 32'h0000_a183, 64'h1008, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 32'h00c1_2223, 64'h100C, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 32'hdead_beef, 64'h1010, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'hcafe_f00d, 64'h1014, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_0000, 64'h0,    1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 64'h0,    1'b1, 1'b0, 3'd3, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0000, 64'h0,    1'b1, 1'b0, 3'd2, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0000, 64'h0,    1'b1, 1'b0, 3'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 64'h0,    1'b0, 1'b0, 3'd0, 1'b1, 1'b0};

        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        #1;
        check("rst_count", 64'(fq.count), 64'd0);
        check("rst_in_ready", 64'(fq.in_ready), 64'd1);
        check("rst_out_valid", 64'(fq.out_valid), 64'd0);
        check("rst_out_instr", 64'(fq.out_instr), 64'(NOP_INSTR));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table: first-word fall-through, fill, drop when full, full+pop, drain.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].valid, vecs[i].instr, vecs[i].pc, vecs[i].ready, vecs[i].flush);
            #1;
            check($sformatf("vec%0d_count", i), 64'(fq.count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d_in_ready", i), 64'(fq.in_ready), 64'(vecs[i].exp_in_ready));
            check($sformatf("vec%0d_out_valid", i), 64'(fq.out_valid), 64'(vecs[i].exp_out_valid));
            if (i == 1) begin
                check("first_instr", 64'(fq.out_instr), 64'h0050_0093);
                check("first_pc", fq.out_pc, 64'h1000);
                check("first_opcode", 64'(fq.out_opcode), 64'h13);
                check("first_funct3", 64'(fq.out_funct3), 64'h0);
            end
            evaluate_and_advance();
        end

        // Steady push+pop at count=2 for 10 cycles; pointers wrap several times.
        step(1'b1, 32'h1111_0013, 64'h2000, 1'b0, 1'b0);
        step(1'b1, 32'h2222_1013, 64'h2004, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h0000_0033 | (32'(k) << 12) | (32'(k) << 20), 64'h2008 + 64'(4 * k), 1'b1, 1'b0);
            #1;
            check($sformatf("steady%0d_count", k), 64'(fq.count), 64'd2);
            evaluate_and_advance();
        end
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Flush at count=3 with a concurrent push and pop request.
        step(1'b1, 32'h0000_1003, 64'h3000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2003, 64'h3004, 1'b0, 1'b0);
        step(1'b1, 32'h0000_3003, 64'h3008, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_4003, 64'h300C, 1'b1, 1'b1);
        #1;
        check("flush_out_valid", 64'(fq.out_valid), 64'd0);
        evaluate_and_advance();
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        #1;
        check("post_flush_count", 64'(fq.count), 64'd0);
        check("post_flush_instr", 64'(fq.out_instr), 64'(NOP_INSTR));
        evaluate_and_advance();
        step(1'b1, 32'h0000_5003, 64'h3010, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with two entries queued.
        step(1'b1, 32'h0000_6013, 64'h4000, 1'b0, 1'b0);
        step(1'b1, 32'h0000_7013, 64'h4004, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        #1;
        check("pre_reset_count", 64'(fq.count), 64'd2);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_count", 64'(fq.count), 64'd0);
        check("async_rst_out_valid", 64'(fq.out_valid), 64'd0);
        check("async_rst_in_ready", 64'(fq.in_ready), 64'd1);
        check("async_rst_instr", 64'(fq.out_instr), 64'(NOP_INSTR));
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 32'h0000_8013, 64'h5000, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
